// File: rtl/emb_lut_pkg.sv
// Shared types and constants for the double-buffered LUT block.
package emb_lut_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } swap_st_e;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 2;

  function automatic int unsigned lut_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/emb_lut_bank.sv
// One LUT bank: simple dual-port RAM with a sync write port and an enabled sync read port.
module emb_lut_bank
  import emb_lut_pkg::*;
#(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned DEPTH = lut_depth(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Read register only loads on a read so the output holds between beats.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/emb_lut_dbuf.sv
// Double-buffered pixel LUT: stream reads the active bank, host fills the shadow bank,
// banks swap only on an accepted start-of-frame beat.
module emb_lut_dbuf
  import emb_lut_pkg::*;
#(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned BYPASS_EN = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enb,
  input  logic              sof,
  input  logic [ADDR_W-1:0] In1,
  input  logic              bypass,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              swap_req,
  output logic              out_valid,
  output logic [DATA_W-1:0] Out1,
  output logic              active_bank,
  output logic              swap_pending,
  output logic              wr_err
);

  if (DATA_W < ADDR_W) begin : g_chk_width
    $error("emb_lut_dbuf: DATA_W must be >= ADDR_W");
  end
  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_chk_lat
    $error("emb_lut_dbuf: RD_LAT must be 1 or 2");
  end

  swap_st_e          state_q, state_d;
  logic              active_bank_q, active_bank_d;
  logic              wr_err_q, wr_err_d;
  logic              vld_q, vld_d;
  logic              byp_q, byp_d;
  logic              sel_q, sel_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  logic              sof_beat, swap_now, rd_sel, wr_ok;
  logic [1:0]        bank_we, bank_re;
  logic [DATA_W-1:0] rd_data [2];
  logic [DATA_W-1:0] lut_data_c;

  // Swap FSM, bank steering and stage-1 pipeline capture.
  always_comb begin
    state_d       = state_q;
    active_bank_d = active_bank_q;
    wr_err_d      = 1'b0;
    vld_d         = enb;
    byp_d         = byp_q;
    sel_d         = sel_q;
    idx_d         = idx_q;
    bank_we       = 2'b00;
    bank_re       = 2'b00;

    sof_beat = enb & sof;
    swap_now = sof_beat & ((state_q == ST_ARMED) | swap_req);
    rd_sel   = active_bank_q ^ swap_now;
    wr_ok    = wr_en & (state_q == ST_IDLE) & ~swap_now;

    case (state_q)
      ST_IDLE:  if (swap_req && !sof_beat) state_d = ST_ARMED;
      ST_ARMED: if (sof_beat) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    active_bank_d = rd_sel;
    wr_err_d      = wr_en & ~wr_ok;

    if (wr_ok) bank_we = active_bank_q ? 2'b01 : 2'b10;
    if (enb) begin
      bank_re = rd_sel ? 2'b10 : 2'b01;
      byp_d   = bypass & (BYPASS_EN != 0);
      sel_d   = rd_sel;
      idx_d   = In1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      active_bank_q <= 1'b0;
      wr_err_q      <= 1'b0;
      vld_q         <= 1'b0;
      byp_q         <= 1'b0;
      sel_q         <= 1'b0;
      idx_q         <= '0;
    end else begin
      state_q       <= state_d;
      active_bank_q <= active_bank_d;
      wr_err_q      <= wr_err_d;
      vld_q         <= vld_d;
      byp_q         <= byp_d;
      sel_q         <= sel_d;
      idx_q         <= idx_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    emb_lut_bank #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rstn),
      .wr_en   (bank_we[b]),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (bank_re[b]),
      .rd_addr (In1),
      .rd_data (rd_data[b])
    );
  end

  // Every term here is a register that only loads on a beat, so the value holds when idle.
  assign lut_data_c = byp_q ? DATA_W'(idx_q) : rd_data[sel_q];

  if (RD_LAT == 2) begin : g_lat2
    logic              out_vld_q, out_vld_d;
    logic [DATA_W-1:0] out_q, out_d;

    always_comb begin
      out_vld_d = vld_q;
      out_d     = out_q;
      if (vld_q) out_d = lut_data_c;
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        out_vld_q <= 1'b0;
        out_q     <= '0;
      end else begin
        out_vld_q <= out_vld_d;
        out_q     <= out_d;
      end
    end

    assign out_valid = out_vld_q;
    assign Out1      = out_q;
  end else begin : g_lat1
    assign out_valid = vld_q;
    assign Out1      = lut_data_c;
  end

  assign active_bank  = active_bank_q;
  assign swap_pending = (state_q == ST_ARMED);
  assign wr_err       = wr_err_q;

endmodule

// File: tb/tb_emb_lut_dbuf.sv
// Randomized bench for emb_lut_dbuf: RD_LAT=1 and RD_LAT=2 instances against a beat-level model.
module tb_emb_lut_dbuf;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, enb, sof, bypass, wr_en, swap_req;
  logic [AW-1:0] in1, wr_addr;
  logic [DW-1:0] wr_data;
  logic          v1, v2, ab1, ab2, sp1, sp2, we1, we2;
  logic [DW-1:0] o1, o2;

  emb_lut_dbuf #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .BYPASS_EN(1)) u_dut_l1 (
    .clk(clk), .rstn(rstn), .enb(enb), .sof(sof), .In1(in1), .bypass(bypass),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .swap_req(swap_req),
    .out_valid(v1), .Out1(o1), .active_bank(ab1), .swap_pending(sp1), .wr_err(we1)
  );

  emb_lut_dbuf #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .BYPASS_EN(1)) u_dut_l2 (
    .clk(clk), .rstn(rstn), .enb(enb), .sof(sof), .In1(in1), .bypass(bypass),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .swap_req(swap_req),
    .out_valid(v2), .Out1(o2), .active_bank(ab2), .swap_pending(sp2), .wr_err(we2)
  );

  int checks = 0;
  int failures = 0;

  // Reference state: two banks, which one is live, whether a swap is armed,
  // and a per-cycle history of (valid, held output) for latency lookups.
  logic [DW-1:0] m_mem [2][DEPTH];
  bit            m_act, m_pend, m_err;
  bit            h_v[$];
  logic [DW-1:0] h_d[$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int n;
    bit ev1, ev2;
    logic [DW-1:0] ed1, ed2;
    n   = h_v.size();
    ev1 = (n >= 1) ? h_v[n-1] : 1'b0;
    ed1 = (n >= 1) ? h_d[n-1] : '0;
    ev2 = (n >= 2) ? h_v[n-2] : 1'b0;
    ed2 = (n >= 2) ? h_d[n-2] : '0;
    chk("valid_l1", DW'(v1), DW'(ev1));
    chk("out1_l1", o1, ed1);
    chk("valid_l2", DW'(v2), DW'(ev2));
    chk("out1_l2", o2, ed2);
    chk("active_l1", DW'(ab1), DW'(m_act));
    chk("active_l2", DW'(ab2), DW'(m_act));
    chk("pending_l1", DW'(sp1), DW'(m_pend));
    chk("pending_l2", DW'(sp2), DW'(m_pend));
    chk("wr_err_l1", DW'(we1), DW'(m_err));
    chk("wr_err_l2", DW'(we2), DW'(m_err));
  endtask

  // Apply one cycle of inputs and advance the model by that beat.
  task automatic drive(input bit e, input bit s, input logic [AW-1:0] a, input bit b,
                       input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input bit sr);
    bit sb, sn, sel;
    logic [DW-1:0] d, last;
    enb = e; sof = s; in1 = a; bypass = b;
    wr_en = we; wr_addr = wa; wr_data = wd; swap_req = sr;
    sb   = e & s;
    sn   = sb & (m_pend | sr);
    sel  = m_act ^ sn;
    d    = b ? DW'(a) : m_mem[sel][a];
    last = (h_d.size() > 0) ? h_d[$] : '0;
    h_v.push_back(e);
    h_d.push_back(e ? d : last);
    m_err = we & (m_pend | sn);
    if (we && !m_pend && !sn) m_mem[!m_act][wa] = wd;
    m_act  = m_act ^ sn;
    m_pend = m_pend ? !sb : (sr & !sb);
  endtask

  task automatic cyc(input bit e, input bit s, input logic [AW-1:0] a, input bit b,
                     input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input bit sr);
    @(negedge clk);
    check_outputs();
    drive(e, s, a, b, we, wa, wd, sr);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic reset_checks();
    chk("rst_valid_l1", DW'(v1), '0);
    chk("rst_valid_l2", DW'(v2), '0);
    chk("rst_out1_l1", o1, '0);
    chk("rst_out1_l2", o2, '0);
    chk("rst_active", DW'(ab1), '0);
    chk("rst_pending", DW'(sp2), '0);
    chk("rst_wr_err", DW'(we1), '0);
  endtask

  // Asynchronous reset mid-stream; the model keeps memory but drops everything in flight.
  task automatic do_reset();
    @(negedge clk);
    check_outputs();
    rstn = 1'b0;
    enb = 1'b0; sof = 1'b0; bypass = 1'b0; wr_en = 1'b0; swap_req = 1'b0;
    #1;
    reset_checks();
    m_act = 1'b0; m_pend = 1'b0; m_err = 1'b0;
    h_v.delete(); h_d.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    rstn = 1'b0;
    enb = 1'b0; sof = 1'b0; in1 = '0; bypass = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; swap_req = 1'b0;
    m_act = 1'b0; m_pend = 1'b0; m_err = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    reset_checks();
    @(negedge clk);
    rstn = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);

    // Fill bank1, swap, fill bank0, swap back in the same cycle as sof.
    for (int i = 0; i < int'(DEPTH); i++) cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, AW'(i), $urandom, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    cyc(1'b1, 1'b1, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < int'(DEPTH); i++) cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, AW'(i), $urandom, 1'b0);
    cyc(1'b1, 1'b1, '0, 1'b0, 1'b0, '0, '0, 1'b1);

    // Load shadow bank1[5] and read the live bank at the same index.
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, AW'(5), 32'hDEADBEEF, 1'b0);
    cyc(1'b1, 1'b0, AW'(5), 1'b0, 1'b0, '0, '0, 1'b0);
    idle(); idle();

    // Armed swap held for three cycles, executed by the sof beat that reads the new bank.
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    idle(); idle(); idle();
    cyc(1'b1, 1'b1, AW'(5), 1'b0, 1'b0, '0, '0, 1'b0);
    idle(); idle();
    chk("sof_new_bank_l1", o1, 32'hDEADBEEF);
    chk("sof_new_bank_l2", o2, 32'hDEADBEEF);
    chk("bank_after_swap", DW'(ab1), DW'(1));

    // Immediate swap, then a repeated request while armed.
    cyc(1'b1, 1'b1, AW'(5), 1'b0, 1'b0, '0, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    cyc(1'b1, 1'b1, AW'(9), 1'b0, 1'b0, '0, '0, 1'b0);
    idle();
    chk("single_toggle", DW'(ab2), DW'(1));

    // Host write while armed is dropped and flagged.
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, AW'(7), 32'h0BADF00D, 1'b0);
    idle();
    chk("wr_err_pulse", DW'(we1), DW'(1));
    cyc(1'b1, 1'b1, AW'(1), 1'b0, 1'b0, '0, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, AW'(7), 32'h12345678, 1'b0);
    cyc(1'b1, 1'b1, AW'(7), 1'b0, 1'b0, '0, '0, 1'b1);
    idle(); idle();
    chk("swap_back_l1", o1, 32'h12345678);
    chk("swap_back_l2", o2, 32'h12345678);

    // Bypass at the top index.
    cyc(1'b1, 1'b0, AW'(11'h7FF), 1'b1, 1'b0, '0, '0, 1'b0);
    idle(); idle();
    chk("bypass_l1", o1, 32'h0000_07FF);
    chk("bypass_l2", o2, 32'h0000_07FF);

    // Back-to-back stream over the full index range with wrap, then reset mid-stream.
    for (int i = 0; i < int'(DEPTH) + 4; i++) cyc(1'b1, (i == 0), AW'(i), 1'b0, 1'b0, '0, '0, 1'b0);
    do_reset();
    idle(); idle(); idle();

    // Random traffic with one more mid-stream reset.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, AW'($urandom),
          $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, AW'($urandom),
          $urandom, $urandom_range(0, 19) == 0);
    end

    repeat (3) idle();
    @(negedge clk);
    check_outputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
